// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module  : morse_pkg
// Brief   : Shared constants, letter patterns and decode helper for the
//           S..Z Morse receiver.
// Revision: 1.0 - initial release
// ============================================================================
package morse_pkg;

  typedef logic [2:0] letter_t;

  localparam int PAT_W = 4;

  localparam letter_t LTR_S = 3'd0;
  localparam letter_t LTR_T = 3'd1;
  localparam letter_t LTR_U = 3'd2;
  localparam letter_t LTR_V = 3'd3;
  localparam letter_t LTR_W = 3'd4;
  localparam letter_t LTR_X = 3'd5;
  localparam letter_t LTR_Y = 3'd6;
  localparam letter_t LTR_Z = 3'd7;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MARK  = 2'd1;
  localparam logic [1:0] SPACE = 2'd2;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam logic [2:0] DASH_MIN   = 3'd2;
  localparam logic [2:0] DASH_MAX   = 3'd3;
  localparam logic [1:0] LETTER_GAP = 2'd3;

  // Bit i holds element i in transmission order (DASH=1).
  localparam logic [PAT_W-1:0] PAT_S = 4'b0000;
  localparam logic [PAT_W-1:0] PAT_T = 4'b0001;
  localparam logic [PAT_W-1:0] PAT_U = 4'b0100;
  localparam logic [PAT_W-1:0] PAT_V = 4'b1000;
  localparam logic [PAT_W-1:0] PAT_W_ = 4'b0110;
  localparam logic [PAT_W-1:0] PAT_X = 4'b1001;
  localparam logic [PAT_W-1:0] PAT_Y = 4'b1101;
  localparam logic [PAT_W-1:0] PAT_Z = 4'b0011;

  localparam logic [2:0] CNT_S = 3'd3;
  localparam logic [2:0] CNT_T = 3'd1;
  localparam logic [2:0] CNT_U = 3'd3;
  localparam logic [2:0] CNT_V = 3'd4;
  localparam logic [2:0] CNT_W = 3'd3;
  localparam logic [2:0] CNT_X = 3'd4;
  localparam logic [2:0] CNT_Y = 3'd4;
  localparam logic [2:0] CNT_Z = 3'd4;

  typedef struct packed {
    logic    hit;
    letter_t code;
  } decode_t;

  function automatic decode_t decode_letter(input logic [2:0] cnt,
                                            input logic [PAT_W-1:0] pat);
    decode_t d;
    d.hit  = 1'b1;
    d.code = LTR_S;
    if      (cnt == CNT_S && pat == PAT_S)  d.code = LTR_S;
    else if (cnt == CNT_T && pat == PAT_T)  d.code = LTR_T;
    else if (cnt == CNT_U && pat == PAT_U)  d.code = LTR_U;
    else if (cnt == CNT_V && pat == PAT_V)  d.code = LTR_V;
    else if (cnt == CNT_W && pat == PAT_W_) d.code = LTR_W;
    else if (cnt == CNT_X && pat == PAT_X)  d.code = LTR_X;
    else if (cnt == CNT_Y && pat == PAT_Y)  d.code = LTR_Y;
    else if (cnt == CNT_Z && pat == PAT_Z)  d.code = LTR_Z;
    else                                    d.hit  = 1'b0;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_receiver_if.sv
`default_nettype none
// ============================================================================
// Module  : morse_receiver_if
// Brief   : Serial line input and decoded-letter outputs of the receiver.
// Revision: 1.0 - initial release
// ============================================================================
interface morse_receiver_if;
  import morse_pkg::*;

  logic    key_in;
  letter_t letter;
  logic    valid;
  logic    error;
  logic    busy;

  modport master (output key_in, input letter, valid, error, busy);
  modport slave  (input key_in, output letter, valid, error, busy);
endinterface
`default_nettype wire

// File: rtl/morse_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : morse_tick_gen
// Brief   : One-cycle tick per Morse unit; realign centres the next sample.
// Revision: 1.0 - initial release
// ============================================================================
module morse_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic clear,
  input  logic realign,
  output logic tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] c_reload = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] c_half   = CW'(TICK_DIV / 2 - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_cnt <= '0;
    end else if (realign) begin
      r_cnt <= c_half;
    end else if (r_cnt == '0) begin
      r_cnt <= c_reload;
    end else begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign tick = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/morse_receiver.sv
`default_nettype none
// ============================================================================
// Module  : morse_receiver
// Brief   : Samples the Morse line once per unit and decodes letters S..Z.
// Revision: 1.0 - initial release
// ============================================================================
module morse_receiver
  import morse_pkg::*;
#(
  parameter int TICK_DIV  = 25000000,
  parameter int MAX_ELEMS = 4
) (
  input  logic             clk,
  input  logic             clear,
  morse_receiver_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_ELEMS + 1);

  logic [1:0]           r_state;
  logic                 r_key_prev;
  logic [2:0]           r_run;
  logic [1:0]           r_gap;
  logic [CNT_W-1:0]     r_count;
  logic [MAX_ELEMS-1:0] r_elems;
  logic                 r_over;
  letter_t              r_letter;
  logic                 r_valid;
  logic                 r_error;

  logic                 w_tick;
  logic                 w_rise;
  logic                 w_realign;
  logic                 w_elem;
  logic                 w_bad;
  logic [PAT_W-1:0]     w_pat;
  decode_t              w_dec;

  assign w_rise    = bus.key_in && !r_key_prev;
  assign w_realign = (r_state == IDLE) && w_rise;

  morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .clear   (clear),
    .realign (w_realign),
    .tick    (w_tick)
  );

  always_comb begin
    w_elem = DOT;
    w_bad  = 1'b0;
    if (r_run == 3'd1) begin
      w_elem = DOT;
    end else if (r_run >= DASH_MIN && r_run <= DASH_MAX) begin
      w_elem = DASH;
    end else begin
      w_bad = 1'b1;
    end
  end

  always_comb begin
    w_pat = '0;
    for (int i = 0; i < PAT_W; i++) begin
      if (i < MAX_ELEMS) w_pat[i] = r_elems[i];
    end
    w_dec = decode_letter(3'(r_count), w_pat);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state    <= IDLE;
      r_key_prev <= 1'b0;
      r_run      <= 3'd0;
      r_gap      <= 2'd0;
      r_count    <= '0;
      r_elems    <= '0;
      r_over     <= 1'b0;
      r_letter   <= LTR_S;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_key_prev <= bus.key_in;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_run   <= 3'd0;
            r_count <= '0;
            r_elems <= '0;
            r_over  <= 1'b0;
            r_state <= MARK;
          end
        end
        MARK: begin
          if (w_tick) begin
            if (bus.key_in) begin
              if (r_run != 3'd7) r_run <= r_run + 3'd1;
            end else begin
              // Count saturates at MAX_ELEMS; any further element marks the letter bad.
              if (r_count < CNT_W'(MAX_ELEMS)) begin
                for (int i = 0; i < MAX_ELEMS; i++) begin
                  if (r_count == CNT_W'(i)) r_elems[i] <= w_elem;
                end
                r_count <= r_count + CNT_W'(1);
              end else begin
                r_over <= 1'b1;
              end
              if (w_bad) r_over <= 1'b1;
              r_gap   <= 2'd1;
              r_state <= SPACE;
            end
          end
        end
        SPACE: begin
          if (w_tick) begin
            if (bus.key_in) begin
              r_run   <= 3'd1;
              r_state <= MARK;
            end else if (r_gap + 2'd1 == LETTER_GAP) begin
              r_state <= IDLE;
              if (w_dec.hit && !r_over) begin
                r_letter <= w_dec.code;
                r_valid  <= 1'b1;
              end else begin
                r_error <= 1'b1;
              end
            end else begin
              r_gap <= r_gap + 2'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.letter = r_letter;
  assign bus.valid  = r_valid;
  assign bus.error  = r_error;
  assign bus.busy   = (r_state != IDLE);
endmodule
`default_nettype wire

// File: doc/morse_receiver.md
Name: morse_receiver

Overview:
- Decodes the serial on/off Morse stream produced by the team's letter transmitter back into a 3-bit letter code.
- Covers letters S..Z: 000=S, 001=T, 010=U, 011=V, 100=W, 101=X, 110=Y, 111=Z.
- Samples the line once per Morse unit, classifies marks as dot or dash, detects end-of-letter, and pulses valid or error.
- Sits at the far end of the LED/serial line, driving HEX/LEDR display logic at top level.

Parameters:
- TICK_DIV, 25000000: clk cycles per Morse unit (0.5 s at 50 MHz); must be at least 4 and even.
- MAX_ELEMS, 4: maximum dots/dashes per letter.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- clear  in  1  asynchronous active-high reset
- key_in  in  1  serial Morse line; 1 = mark (on), 0 = space; synchronous to clk
- letter  out  3  last decoded letter code; holds until the next valid
- valid  out  1  one-cycle pulse when letter is updated
- error  out  1  one-cycle pulse on an undecodable letter
- busy  out  1  high while a letter is in progress (state != IDLE)

Behaviour:
- Reset (clear=1, async, dominates every other input):
  - letter=000, valid=0, error=0, busy=0.
  - State IDLE; element count=0; tick counter=0.
- Line format:
  - dot = 1 unit mark; dash = 3 units mark.
  - Inter-element gap = 1 unit space; end of letter = 3 or more units space.
- Tick generator:
  - Counts TICK_DIV-1 down to 0 and asserts tick for one cycle at 0, then reloads.
  - On realign, loads TICK_DIV/2-1 so the first sample lands mid-unit.
- IDLE:
  - Waits for a key_in rising edge (registered previous value 0, current value 1).
  - On the edge: realign tick, run=0, elems cleared, over=0, go to MARK.
- MARK, on each tick:
  - key_in=1: run=run+1, saturating at 7.
  - key_in=0: classify run: 1 -> dot; 2 or 3 -> dash; 0 or 4+ -> set over flag.
  - Append the element (dash=1) at index count, count+1. A 5th element sets over.
  - Set gap=1 and go to SPACE.
- SPACE, on each tick:
  - key_in=1: run=1, go to MARK.
  - key_in=0: gap+1. When gap reaches 3: decode, emit, go to IDLE.
- Decode table (count, elements in order):
  - S 3 ...
  - T 1 -
  - U 3 ..-
  - V 4 ...-
  - W 3 .--
  - X 4 -..-
  - Y 4 -.--
  - Z 4 --..
- Emit:
  - Match with over=0: letter updated and valid=1 on the same edge, for exactly one cycle.
  - Otherwise: error=1 for one cycle and letter unchanged.
  - valid and error are never high together.
- key_in is only sampled on ticks. Glitches shorter than one unit that miss a tick are ignored.
- A mark held indefinitely stays in MARK with run saturated and produces error when released.
- Emit-cycle behaviour: the cycle that returns to IDLE samples no edge. A rising edge on the next cycle starts a new letter normally.
- clear mid-letter: the partial letter is discarded, no pulse is produced, and letter returns to 000.

Decomposition:
- Package morse_pkg holds:
  - Letter code constants LTR_S..LTR_Z.
  - State encoding: IDLE, MARK, SPACE.
  - Element encoding: DOT=0, DASH=1.
  - Thresholds: DASH_MIN=2, DASH_MAX=3, LETTER_GAP=3.
  - The eight pattern/count constants.
- One sub-module, morse_tick_gen:
  - Ports: clk, clear, realign, tick; parameter TICK_DIV.
  - The FSM, element register and decode logic stay in morse_receiver.

Test Plan (TICK_DIV=4, so each unit is 4 clk cycles held on key_in):
- Units 1,0,1,0,1,0,0,0 -> one valid pulse, letter=000 (S), error never high, busy low afterwards.
- Units 1,1,1,0,1,1,1,0,1,0,1,0,0,0 -> valid, letter=111 (Z). Then 1,1,1,0,0,0 -> valid, letter=001 (T).
- Units 1,0,1,0,1,0,1,0,0,0 (four dots, H) -> error pulse, valid=0, letter unchanged from the previous value.
- Units 1,1,1,1,1,0,0,0 (5-unit mark) -> error pulse. Then 1,0,1,0,1,1,1,0,0,0 -> valid, letter=010 (U).
- Units 1,0,1 then clear high for 2 cycles -> all outputs 0 asynchronously, no pulse. Then 1,0,1,0,1,0,1,1,1,0,0,0 -> valid, letter=011 (V).
- One-cycle key_in glitch between ticks during SPACE of S -> still decodes letter=000 with a single valid pulse.
